// File: rtl/mem_scan_pkg.sv
// Shared types and default sizing for the memory scan controller.
// Optional looping mode is selected with MEM_SCAN_WRAP_EN (see mem_scan_ctrl).
package mem_scan_pkg;

    localparam int MEM_DEPTH = 16;
    localparam int MEM_AW    = 4;
    localparam int MEM_DW    = 8;

    typedef enum logic [1:0] {
        IDLE,
        RESTART,
        WAIT,
        ADVANCE
    } scan_state_t;

endpackage

// File: rtl/edge_rise_det.sv
// Registered rising-edge detector: rise is high in the first cycle sig_in
// is seen high after being low at the previous clock edge.
module edge_rise_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);

    logic sig_d;
    logic sig_q;

    always_comb begin
        sig_d = sig_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/mem_scan_ctrl.sv
// Register-file memory written from switches and scanned one entry per
// timer expiry. Define MEM_SCAN_WRAP_EN to loop the scan continuously.
module mem_scan_ctrl
    import mem_scan_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          scan_start,
    input  logic          timeout,
    output logic          timer_restart,
    output logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          scanning,
    output logic          done
);

    scan_state_t   state_q;
    scan_state_t   state_d;
    logic [AW-1:0] rd_addr_q;
    logic [AW-1:0] rd_addr_d;
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          tmo_rise;
    logic          last_addr;

    // Only a fresh expiry edge counts; the sticky timeout level is ignored.
    edge_rise_det u_tmo_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_in (timeout),
        .rise   (tmo_rise)
    );

    assign last_addr = (rd_addr_q == AW'(DEPTH - 1));

    // Read data looks at the post-write memory image so a write to the
    // displayed address shows up without an extra cycle of stale data.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
        rd_data_d = mem_d[rd_addr_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    rd_addr_d = '0;
                    state_d   = RESTART;
                end
            end
            RESTART: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A restart request takes priority over a coincident expiry.
                if (scan_start) begin
                    rd_addr_d = '0;
                    state_d   = RESTART;
                end else if (tmo_rise) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (last_addr) begin
`ifdef MEM_SCAN_WRAP_EN
                    rd_addr_d = '0;
                    state_d   = RESTART;
`else
                    state_d   = IDLE;
`endif
                end else begin
                    rd_addr_d = rd_addr_q + AW'(1);
                    state_d   = RESTART;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        timer_restart = 1'b0;
        scanning      = 1'b0;
        done          = 1'b0;
        case (state_q)
            RESTART: begin
                timer_restart = 1'b1;
                scanning      = 1'b1;
            end
            WAIT: begin
                scanning = 1'b1;
            end
            ADVANCE: begin
                scanning = 1'b1;
                done     = last_addr;
            end
            default: begin
                scanning = 1'b0;
            end
        endcase
    end

    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Testbench for mem_scan_ctrl with an emulated interval timer and an
// event-timestamp reference model; honours MEM_SCAN_WRAP_EN like the design.
module tb_mem_scan_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          scan_start;
    logic          timeout;
    logic          timer_restart;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          scanning;
    logic          done;

    int checks = 0;
    int errors = 0;

    // Emulated timer and event counters seen by the stimulus side.
    bit tmr_auto     = 1'b0;
    int tmr_interval = 10;
    int tmr_cnt      = 0;
    bit tb_prev_tmo  = 1'b0;
    int rises        = 0;
    int restarts     = 0;
    int dones        = 0;

    // Reference model state: scan progress expressed as event timestamps.
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rdata;
    bit            m_busy;
    int            m_addr;
    int            m_restart_cyc;
    int            m_step_cyc;
    bit            m_prev_tmo;
    int            cyc = 0;

    always #5 clk = ~clk;

    mem_scan_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .scan_start    (scan_start),
        .timeout       (timeout),
        .timer_restart (timer_restart),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .scanning      (scanning),
        .done          (done)
    );

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // One clock cycle: tally this cycle's events, cross the edge, then
    // clear pulse inputs and advance the emulated timer.
    task automatic apply_stimulus();
        bit rs;
        rs = timer_restart;
        if (timer_restart) restarts++;
        if (done) dones++;
        if (reset) begin
            tb_prev_tmo = 1'b0;
        end else begin
            if (timeout && !tb_prev_tmo) rises++;
            tb_prev_tmo = timeout;
        end
        @(posedge clk);
        #1;
        wr_en      = 1'b0;
        scan_start = 1'b0;
        if (tmr_auto) begin
            if (rs) begin
                tmr_cnt = (tmr_interval == 0) ? int'($urandom_range(3, 12)) : tmr_interval;
                timeout = 1'b0;
            end else if (tmr_cnt > 0) begin
                tmr_cnt--;
                if (tmr_cnt == 0) timeout = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) apply_stimulus();
        reset = 1'b0;
        apply_stimulus();
    endtask

    task automatic manual_rise();
        timeout = 1'b1;
        apply_stimulus();
        timeout = 1'b0;
        repeat (4) apply_stimulus();
    endtask

    task automatic start_scan_manual();
        scan_start = 1'b1;
        apply_stimulus();
        repeat (3) apply_stimulus();
    endtask

    // Reference model: compare on the falling edge, then fold in this
    // cycle's inputs to predict the next cycle.
    always @(negedge clk) begin
        bit rise;
        bit waiting;
        bit exp_restart;
        bit exp_done;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_rdata       = '0;
            m_busy        = 1'b0;
            m_addr        = 0;
            m_restart_cyc = -10;
            m_step_cyc    = -1;
            m_prev_tmo    = 1'b0;
        end else begin
            exp_restart = m_busy && (cyc == m_restart_cyc);
            exp_done    = m_busy && (cyc == m_step_cyc) && (m_addr == DEPTH - 1);
            check_output("model_rd_addr", rd_addr, m_addr);
            check_output("model_rd_data", rd_data, m_rdata);
            check_output("model_scanning", scanning, m_busy);
            check_output("model_timer_restart", timer_restart, exp_restart);
            check_output("model_done", done, exp_done);

            rise    = timeout && !m_prev_tmo;
            waiting = m_busy && (cyc > m_restart_cyc) && (m_step_cyc < 0);
            if (wr_en) m_mem[wr_addr] = wr_data;
            m_rdata = m_mem[m_addr];

            if (scan_start && (!m_busy || waiting)) begin
                m_busy        = 1'b1;
                m_addr        = 0;
                m_restart_cyc = cyc + 1;
                m_step_cyc    = -1;
            end else if (waiting && rise) begin
                m_step_cyc = cyc + 1;
            end else if (m_busy && (cyc == m_step_cyc)) begin
                m_step_cyc = -1;
                if (m_addr == DEPTH - 1) begin
`ifdef MEM_SCAN_WRAP_EN
                    m_addr        = 0;
                    m_restart_cyc = cyc + 1;
`else
                    m_busy = 1'b0;
`endif
                end else begin
                    m_addr        = m_addr + 1;
                    m_restart_cyc = cyc + 1;
                end
            end
            m_prev_tmo = timeout;
        end
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int budget;
        int r0;
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        scan_start = 1'b0;
        timeout    = 1'b0;
        #1;

        // Reset state
        repeat (3) apply_stimulus();
        check_output("reset_rd_addr", rd_addr, 0);
        check_output("reset_rd_data", rd_data, 0);
        check_output("reset_flags", {timer_restart, scanning, done}, 3'b000);
        reset = 1'b0;
        apply_stimulus();
        check_output("post_reset_scanning", scanning, 0);

        // Write then scan with the emulated timer
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_data = 8'hA5;
        apply_stimulus();
        tmr_auto     = 1'b1;
        tmr_interval = 10;
        rises        = 0;
        restarts     = 0;
        dones        = 0;
        scan_start   = 1'b1;
        apply_stimulus();
        budget = 200;
        while (rd_addr != 4'd3 && budget > 0) begin
            apply_stimulus();
            budget--;
        end
        check_output("wr_rd_addr_at_3", rd_addr, 3);
        check_output("wr_rd_rises_at_3", rises, 3);
        apply_stimulus();
        check_output("wr_rd_data_a5", rd_data, 8'hA5);

        // Complete the pass
        budget = 400;
        while (dones == 0 && budget > 0) begin
            apply_stimulus();
            budget--;
        end
        check_output("scan_done_seen", dones, 1);
        check_output("scan_restarts", restarts, 16);
        check_output("scan_rises", rises, 16);
`ifdef MEM_SCAN_WRAP_EN
        check_output("wrap_rd_addr", rd_addr, 0);
        check_output("wrap_scanning", scanning, 1);
        check_output("wrap_restart", timer_restart, 1);
`else
        check_output("end_rd_addr", rd_addr, 15);
        check_output("end_scanning", scanning, 0);
        repeat (20) apply_stimulus();
        check_output("end_single_done", dones, 1);
`endif

        // Sticky timeout: only a fresh edge advances
        tmr_auto = 1'b0;
        timeout  = 1'b0;
        do_reset();
        timeout = 1'b1;
        repeat (3) apply_stimulus();
        scan_start = 1'b1;
        apply_stimulus();
        repeat (10) apply_stimulus();
        check_output("sticky_hold_addr", rd_addr, 0);
        check_output("sticky_hold_scanning", scanning, 1);
        timeout = 1'b0;
        apply_stimulus();
        timeout = 1'b1;
        repeat (4) apply_stimulus();
        check_output("sticky_fresh_edge", rd_addr, 1);
        repeat (8) apply_stimulus();
        check_output("sticky_after_restart", rd_addr, 1);
        timeout = 1'b0;

        // Collision of scan_start and expiry in WAIT at address 7
        do_reset();
        start_scan_manual();
        repeat (7) manual_rise();
        check_output("col_setup_addr", rd_addr, 7);
        r0         = restarts;
        timeout    = 1'b1;
        scan_start = 1'b1;
        apply_stimulus();
        check_output("col_addr_zero", rd_addr, 0);
        repeat (6) apply_stimulus();
        check_output("col_one_restart", restarts - r0, 1);
        check_output("col_no_advance", rd_addr, 0);
        timeout = 1'b0;

        // Asynchronous reset mid-WAIT at address 5
        do_reset();
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 8'h3C;
        apply_stimulus();
        start_scan_manual();
        repeat (5) manual_rise();
        check_output("ar_setup_addr", rd_addr, 5);
        check_output("ar_setup_data", rd_data, 8'h3C);
        #1;
        reset = 1'b1;
        #1;
        check_output("ar_rd_addr", rd_addr, 0);
        check_output("ar_rd_data", rd_data, 0);
        check_output("ar_flags", {timer_restart, scanning, done}, 3'b000);
        repeat (2) apply_stimulus();
        reset = 1'b0;
        apply_stimulus();
        start_scan_manual();
        repeat (5) manual_rise();
        check_output("ar_mem_cleared_addr", rd_addr, 5);
        check_output("ar_mem_cleared_data", rd_data, 0);

        // Randomized traffic against the model
        tmr_auto     = 1'b1;
        tmr_interval = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            wr_en      = ($urandom_range(0, 5) == 0);
            wr_addr    = AW'($urandom);
            wr_data    = DW'($urandom);
            scan_start = ($urandom_range(0, 199) == 0);
            if (i % 900 == 899) reset = 1'b1;
            if (i % 900 == 902) reset = 1'b0;
            apply_stimulus();
        end
        reset = 1'b0;
        repeat (5) apply_stimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
